// File: rtl/nn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : nn_layer_engine
// Brief    : Multi-lane dot-product engine for one fully-connected layer, with
//            fixed-point scaling, saturation and an internal result file.
//            Optional ReLU on stored results when NN_RELU_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module nn_layer_engine #(
    parameter int PIX_W       = 16,
    parameter int WGT_W       = 16,
    parameter int LANES       = 2,
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_OUTPUTS = 10,
    parameter int ACC_W       = 40,
    parameter int RES_W       = 16,
    parameter int FRAC        = 8,
    localparam int WORDS      = NUM_INPUTS / LANES,
    localparam int PA_W       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int WA_W       = (NUM_OUTPUTS * WORDS > 1) ? $clog2(NUM_OUTPUTS * WORDS) : 1,
    localparam int RA_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   res_valid,
    output logic                   pix_ren,
    output logic [PA_W-1:0]        pix_addr,
    input  logic [LANES*PIX_W-1:0] pix_rdata,
    output logic                   wgt_ren,
    output logic [WA_W-1:0]        wgt_addr,
    input  logic [LANES*WGT_W-1:0] wgt_rdata,
    input  logic [RA_W-1:0]        res_raddr,
    output logic [RES_W-1:0]       res_rdata
);

    localparam int PROD_W = PIX_W + WGT_W;

    localparam logic [PA_W-1:0]         c_last_k   = PA_W'(WORDS - 1);
    localparam logic [RA_W-1:0]         c_last_row = RA_W'(NUM_OUTPUTS - 1);
    localparam logic signed [ACC_W-1:0] c_res_max  = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_res_min  = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    logic [PA_W-1:0]          r_k;
    logic [RA_W-1:0]          r_row;
    logic                     r_rd_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [RES_W-1:0]  r_result [NUM_OUTPUTS];

    logic signed [PROD_W-1:0] w_prod [LANES];
    logic signed [ACC_W-1:0]  w_lane_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic signed [RES_W-1:0]  w_sat;
    logic signed [RES_W-1:0]  w_store;

    // Operands are widened to the full product width first so the multiply
    // is a same-width signed operation.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [PROD_W-1:0] w_pix_ext;
            logic signed [PROD_W-1:0] w_wgt_ext;
            assign w_pix_ext = PROD_W'($signed(pix_rdata[i*PIX_W +: PIX_W]));
            assign w_wgt_ext = PROD_W'($signed(wgt_rdata[i*WGT_W +: WGT_W]));
            assign w_prod[i] = w_pix_ext * w_wgt_ext;
        end
    endgenerate

    always_comb begin
        w_lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + ACC_W'(w_prod[i]);
        end
    end

    assign w_shift  = r_acc >>> FRAC;
    assign w_sat_hi = (w_shift > c_res_max);
    assign w_sat_lo = (w_shift < c_res_min);

    always_comb begin
        if (w_sat_hi) begin
            w_sat = c_res_max[RES_W-1:0];
        end else if (w_sat_lo) begin
            w_sat = c_res_min[RES_W-1:0];
        end else begin
            w_sat = w_shift[RES_W-1:0];
        end
    end

`ifdef NN_RELU_EN
    assign w_store = w_sat[RES_W-1] ? '0 : w_sat;
`else
    assign w_store = w_sat;
`endif

    assign res_rdata = (int'(res_raddr) < NUM_OUTPUTS) ? r_result[res_raddr] : '0;

    // Read data lags the issued address by one cycle, so accumulation is
    // keyed off a delayed copy of the read enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            res_valid <= 1'b0;
            pix_ren   <= 1'b0;
            wgt_ren   <= 1'b0;
            pix_addr  <= '0;
            wgt_addr  <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_acc     <= '0;
            r_rd_vld  <= 1'b0;
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
                r_result[i] <= '0;
            end
        end else begin
            r_rd_vld <= pix_ren;
            if (r_rd_vld) begin
                r_acc <= r_acc + w_lane_sum;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_READ;
                        busy      <= 1'b1;
                        overflow  <= 1'b0;
                        res_valid <= 1'b0;
                        r_row     <= '0;
                        r_k       <= '0;
                        r_acc     <= '0;
                        pix_ren   <= 1'b1;
                        wgt_ren   <= 1'b1;
                        pix_addr  <= '0;
                        wgt_addr  <= '0;
                    end
                end

                S_READ: begin
                    if (r_k == c_last_k) begin
                        pix_ren <= 1'b0;
                        wgt_ren <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k      <= r_k + 1'b1;
                        pix_addr <= r_k + 1'b1;
                        wgt_addr <= wgt_addr + 1'b1;
                    end
                end

                S_DRAIN: begin
                    r_state <= S_STORE;
                end

                S_STORE: begin
                    r_result[r_row] <= w_store;
                    r_acc           <= '0;
                    if (w_sat_hi || w_sat_lo) begin
                        overflow <= 1'b1;
                    end
                    if (r_row == c_last_row) begin
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        res_valid <= 1'b1;
                    end else begin
                        // Weight rows are contiguous, so the next row starts
                        // one word past the last address issued.
                        r_row    <= r_row + 1'b1;
                        r_k      <= '0;
                        pix_addr <= '0;
                        wgt_addr <= wgt_addr + 1'b1;
                        pix_ren  <= 1'b1;
                        wgt_ren  <= 1'b1;
                        r_state  <= S_READ;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_engine
// Brief    : Self-checking bench for nn_layer_engine (4 inputs, 2 outputs,
//            2 lanes); honours NN_RELU_EN in its expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_layer_engine;

`ifdef NN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, overflow, res_valid;
    logic        pix_ren, wgt_ren;
    logic [0:0]  pix_addr;
    logic [1:0]  wgt_addr;
    logic [31:0] pix_rdata, wgt_rdata;
    logic [0:0]  res_raddr;
    logic [15:0] res_rdata;

    logic        f_start;
    logic        f_busy, f_done, f_overflow, f_res_valid;
    logic        f_pix_ren, f_wgt_ren;
    logic [0:0]  f_pix_addr;
    logic [1:0]  f_wgt_addr;
    logic [31:0] f_pix_rdata, f_wgt_rdata;
    logic [0:0]  f_res_raddr;
    logic [15:0] f_res_rdata;

    logic signed [15:0] pix_mem [4];
    logic signed [15:0] wgt_mem [8];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0]        pix;
        logic [127:0]       wgt;
        logic signed [15:0] r0;
        logic signed [15:0] r1;
        logic               ovf;
    } vec_t;

    typedef struct {
        logic signed [15:0] r0;
        logic signed [15:0] r1;
        logic               ovf;
    } exp_t;

    exp_t sb[$];
    int   pa_q[$];
    int   wa_q[$];

    nn_layer_engine #(
        .PIX_W(16), .WGT_W(16), .LANES(2), .NUM_INPUTS(4), .NUM_OUTPUTS(2),
        .ACC_W(40), .RES_W(16), .FRAC(0)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .overflow(overflow), .res_valid(res_valid),
        .pix_ren(pix_ren), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
        .wgt_ren(wgt_ren), .wgt_addr(wgt_addr), .wgt_rdata(wgt_rdata),
        .res_raddr(res_raddr), .res_rdata(res_rdata)
    );

    nn_layer_engine #(
        .PIX_W(16), .WGT_W(16), .LANES(2), .NUM_INPUTS(4), .NUM_OUTPUTS(2),
        .ACC_W(40), .RES_W(16), .FRAC(8)
    ) u_dut_frac (
        .clk(clk), .rst(rst), .start(f_start), .busy(f_busy), .done(f_done),
        .overflow(f_overflow), .res_valid(f_res_valid),
        .pix_ren(f_pix_ren), .pix_addr(f_pix_addr), .pix_rdata(f_pix_rdata),
        .wgt_ren(f_wgt_ren), .wgt_addr(f_wgt_addr), .wgt_rdata(f_wgt_rdata),
        .res_raddr(f_res_raddr), .res_rdata(f_res_rdata)
    );

    always #5 clk = ~clk;

    // One-cycle-latency SRAM models
    always @(posedge clk) begin
        if (pix_ren)   pix_rdata   <= {pix_mem[{pix_addr, 1'b1}], pix_mem[{pix_addr, 1'b0}]};
        if (wgt_ren)   wgt_rdata   <= {wgt_mem[{wgt_addr, 1'b1}], wgt_mem[{wgt_addr, 1'b0}]};
        if (f_pix_ren) f_pix_rdata <= {pix_mem[{f_pix_addr, 1'b1}], pix_mem[{f_pix_addr, 1'b0}]};
        if (f_wgt_ren) f_wgt_rdata <= {wgt_mem[{f_wgt_addr, 1'b1}], wgt_mem[{f_wgt_addr, 1'b0}]};
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] rl(input int v);
        if (RELU && v < 0) return 16'sd0;
        return 16'(v);
    endfunction

    function automatic logic [63:0] pk4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) pix_mem[i] = v.pix[i*16 +: 16];
        for (int i = 0; i < 8; i++) wgt_mem[i] = v.wgt[i*16 +: 16];
    endtask

    task automatic read_res(input int idx, output logic signed [15:0] v);
        res_raddr = 1'(idx);
        #1;
        v = res_rdata;
    endtask

    // Drives one start, optionally extra start pulses and a mid-run reset,
    // and compares results against the scoreboard whenever done appears.
    task automatic run_layer(input int p1, input int p2, input int rst_at,
                             output int lat, output int ndone);
        logic signed [15:0] v;
        exp_t e;
        lat   = -1;
        ndone = 0;
        pa_q.delete();
        wa_q.delete();
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = (n == p1 || n == p2);
            if (n == rst_at + 1) rst = 1'b0;
            if (n == 1) begin
                check("busy_after_start", busy, 1);
                check("res_valid_cleared", res_valid, 0);
            end
            if (pix_ren) pa_q.push_back(int'(pix_addr));
            if (wgt_ren) wa_q.push_back(int'(wgt_addr));
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    read_res(0, v);
                    check("result0", v, e.r0);
                    read_res(1, v);
                    check("result1", v, e.r1);
                    check("overflow", overflow, e.ovf);
                    check("res_valid", res_valid, 1);
                end
            end
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_ren", pix_ren, 0);
                read_res(0, v);
                check("rst_res0", v, 0);
                read_res(1, v);
                check("rst_res1", v, 0);
            end
        end
        while (sb.size() > 0) begin
            void'(sb.pop_front());
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected a done pulse");
        end
        check("busy_end", busy, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int lat, nd;
        exp_t e;
        logic signed [15:0] v;

        vecs[0] = '{pk4(1, 1, 1, 1), {pk4(-1, -1, -1, -1), pk4(1, 2, 3, 4)}, rl(10), rl(-4), 1'b0};
        vecs[1] = '{pk4(32767, 32767, 32767, 32767),
                    {pk4(32767, 32767, 32767, 32767), pk4(32767, 32767, 32767, 32767)},
                    rl(32767), rl(32767), 1'b1};
        vecs[2] = '{pk4(32767, 32767, 32767, 32767),
                    {pk4(-32768, -32768, -32768, -32768), pk4(-32768, -32768, -32768, -32768)},
                    rl(-32768), rl(-32768), 1'b1};
        vecs[3] = '{pk4(-3, 5, 7, -2), {pk4(100, 100, 100, 100), pk4(2, -4, 1, 10)},
                    rl(-39), rl(700), 1'b0};
        vecs[4] = '{pk4(32767, 1, 0, 0), {pk4(-1, -1, 0, 0), pk4(1, 0, 0, 0)},
                    rl(32767), rl(-32768), 1'b0};

        rst = 1'b1; start = 1'b0; f_start = 1'b0; res_raddr = '0; f_res_raddr = '0;
        pix_rdata = '0; wgt_rdata = '0; f_pix_rdata = '0; f_wgt_rdata = '0;
        for (int i = 0; i < 4; i++) pix_mem[i] = '0;
        for (int i = 0; i < 8; i++) wgt_mem[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_overflow", overflow, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_ren", pix_ren | wgt_ren, 0);
        check("reset_addr", {pix_addr, wgt_addr}, 0);
        read_res(0, v);
        check("reset_res0", v, 0);
        read_res(1, v);
        check("reset_res1", v, 0);

        for (int i = 0; i < 5; i++) begin
            load(vecs[i]);
            e.r0 = vecs[i].r0; e.r1 = vecs[i].r1; e.ovf = vecs[i].ovf;
            sb.push_back(e);
            run_layer(-1, -1, -1, lat, nd);
            check("done_latency", lat, 9);
            check("done_count", nd, 1);
            check("res_valid_held", res_valid, 1);
            if (i == 0) begin
                check("pix_ren_cycles", pa_q.size(), 4);
                check("wgt_ren_cycles", wa_q.size(), 4);
                for (int k = 0; k < pa_q.size() && k < 4; k++) begin
                    check("pix_addr_seq", pa_q[k], k % 2);
                    check("wgt_addr_seq", wa_q[k], k);
                end
            end
        end

        // start pulses while busy must be ignored
        load(vecs[0]);
        e.r0 = vecs[0].r0; e.r1 = vecs[0].r1; e.ovf = vecs[0].ovf;
        sb.push_back(e);
        run_layer(3, 8, -1, lat, nd);
        check("busy_start_latency", lat, 9);
        check("busy_start_done_count", nd, 1);

        // reset mid-run aborts with no done, then a fresh layer runs fully
        load(vecs[3]);
        run_layer(-1, -1, 4, lat, nd);
        check("rst_mid_done_count", nd, 0);
        check("rst_mid_res_valid", res_valid, 0);
        load(vecs[0]);
        e.r0 = vecs[0].r0; e.r1 = vecs[0].r1; e.ovf = vecs[0].ovf;
        sb.push_back(e);
        run_layer(-1, -1, -1, lat, nd);
        check("after_rst_latency", lat, 9);

        // FRAC=8 instance: row0 sums to -1, row1 to -257; both floor
        pix_mem[0] = 16'sd1; pix_mem[1] = 16'sd1; pix_mem[2] = 16'sd0; pix_mem[3] = 16'sd0;
        wgt_mem[0] = -16'sd1; wgt_mem[1] = 16'sd0; wgt_mem[2] = 16'sd0; wgt_mem[3] = 16'sd0;
        wgt_mem[4] = -16'sd256; wgt_mem[5] = -16'sd1; wgt_mem[6] = 16'sd0; wgt_mem[7] = 16'sd0;
        f_start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            f_start = 1'b0;
            if (f_done && lat < 0) begin
                lat = n;
                f_res_raddr = 1'b0;
                #1;
                check("frac_result0", $signed(f_res_rdata), rl(-1));
                f_res_raddr = 1'b1;
                #1;
                check("frac_result1", $signed(f_res_rdata), rl(-2));
                check("frac_overflow", f_overflow, 0);
            end
        end
        check("frac_latency", lat, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
